// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states, Booth
// step operations and the iteration counter sizing helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Wide enough to hold the value n itself, so the counter never wraps.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_booth_mult_if.sv
// Operand/product handshake bundle for seq_booth_mult.
// A transfer happens on a rising edge where valid & ready are both 1; the
// sender holds its data stable until then, and ready never depends on valid.
interface seq_booth_mult_if #(
    parameter int WIDTH = 16
) ();

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, multiplicand, multiplier, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth iteration: add/subtract M into A from {Q[0],Q-1}, then an
// arithmetic right shift of {A,Q,Q-1} by one bit. Purely combinational.
module booth_step
    import seq_mult_pkg::*;
#(
    parameter int N = 17
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] q_i,
    input  logic         qm1_i,
    input  logic [N-1:0] m_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] q_o,
    output logic         qm1_o
);

    booth_op_t    op;
    logic [N-1:0] sum;

    always_comb begin
        op = NOP;
        case ({q_i[0], qm1_i})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase

        // N-bit arithmetic; carries out of the top bit are dropped on purpose.
        sum = a_i;
        case (op)
            ADD:     sum = a_i + m_i;
            SUB:     sum = a_i - m_i;
            default: sum = a_i;
        endcase

        a_o   = {sum[N-1], sum[N-1:1]};
        q_o   = {sum[0], q_i[N-1:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier, one Booth step per cycle over WIDTH+1
// bits so signed and unsigned operands share the same datapath.
module seq_booth_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_booth_mult_if.slave      bus,
    output state_t               dbg_state
);

    localparam int N  = WIDTH + 1;
    localparam int CW = cnt_width(N);

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [N-1:0]       m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [N-1:0]       a_nxt;
    logic [N-1:0]       q_nxt;
    logic               qm1_nxt;

    booth_step #(.N(N)) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (a_nxt),
        .q_o   (q_nxt),
        .qm1_o (qm1_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = BUSY;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    if (bus.signed_mode) begin
                        m_d = {bus.multiplicand[WIDTH-1], bus.multiplicand};
                        q_d = {bus.multiplier[WIDTH-1], bus.multiplier};
                    end else begin
                        m_d = {1'b0, bus.multiplicand};
                        q_d = {1'b0, bus.multiplier};
                    end
                end
            end
            BUSY: begin
                a_d   = a_nxt;
                q_d   = q_nxt;
                qm1_d = qm1_nxt;
                cnt_d = cnt_q + 1'b1;
                // Last step: the two extension bits at the top of A are dropped.
                if (cnt_q == CW'(N - 1)) begin
                    state_d   = DONE;
                    product_d = {a_nxt[N-3:0], q_nxt};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE) && !rst;
    assign bus.product   = product_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed and randomised checks of seq_booth_mult at WIDTH=16, with an
// arithmetic reference model feeding an expected-value queue.
module tb_seq_booth_mult;
    import seq_mult_pkg::*;

    localparam int WIDTH = 16;
    localparam int LAT   = WIDTH + 1;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    seq_booth_mult_if #(.WIDTH(WIDTH)) bus ();

    seq_booth_mult #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_rel_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_rel_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
    endtask

    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] m,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic sm);
        logic [63:0] a, b, p;
        a = sm ? {{(64-WIDTH){m[WIDTH-1]}}, m} : {{(64-WIDTH){1'b0}}, m};
        b = sm ? {{(64-WIDTH){q[WIDTH-1]}}, q} : {{(64-WIDTH){1'b0}}, q};
        p = a * b;
        return p[2*WIDTH-1:0];
    endfunction

    // Driver: one full transaction. hold = cycles of out_ready=0 backpressure,
    // noise = scramble inputs while the operation is running.
    task automatic do_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                         input logic sm, input int hold, input bit noise,
                         output logic [2*WIDTH-1:0] prod);
        int wait_n;
        int lat;
        wait_n = 0;
        while (!bus.in_ready && wait_n < 50) begin
            tick();
            wait_n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid     = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.signed_mode  = sm;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (noise) begin
                bus.in_valid     = 1'($urandom_range(0, 1));
                bus.multiplicand = WIDTH'($urandom_range(0, 65535));
                bus.multiplier   = WIDTH'($urandom_range(0, 65535));
                bus.signed_mode  = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", 64'(lat), 64'(LAT));
        prod = bus.product;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_product", 64'(bus.product), 64'(prod));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_product_kept", 64'(bus.product), 64'(prod));
    endtask

    initial begin
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] exp;
        logic [WIDTH-1:0]   rm, rq;
        logic               rs;

        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.signed_mode  = 1'b0;
        bus.out_ready    = 1'b0;
        do_reset();

        // out_ready outside DONE is ignored
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_out_ready_ignored", 64'(dbg_state), 64'(IDLE));

        do_op(16'hFFFD, 16'h0005, 1'b1, 0, 1'b0, prod);
        check("signed_m3x5", 64'(prod), 64'hFFFF_FFF1);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, prod);
        check("unsigned_ffff_sq", 64'(prod), 64'hFFFE_0001);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, prod);
        check("signed_m1_sq", 64'(prod), 64'h0000_0001);
        do_op(16'h8000, 16'h8000, 1'b1, 0, 1'b0, prod);
        check("signed_min_sq", 64'(prod), 64'h4000_0000);
        do_op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0, prod);
        check("signed_min_max", 64'(prod), 64'hC000_8000);
        do_op(16'h1234, 16'h0010, 1'b0, 10, 1'b0, prod);
        check("backpressure_prod", 64'(prod), 64'h0001_2340);

        // reset in the middle of BUSY after 8 Booth steps
        bus.in_valid     = 1'b1;
        bus.multiplicand = 16'h00AB;
        bus.multiplier   = 16'h00CD;
        bus.signed_mode  = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("midbusy_state", 64'(dbg_state), 64'(BUSY));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_product", 64'(bus.product), 64'd0);
        do_op(16'd7, 16'd9, 1'b0, 0, 1'b0, prod);
        check("after_rst_7x9", 64'(prod), 64'h0000_003F);

        // inputs scrambled while busy must not disturb the accepted pair
        do_op(16'h0123, 16'hFF00, 1'b1, 1, 1'b1, prod);
        check("noise_signed", 64'(prod), 64'hFFFE_DD00);
        do_op(16'hABCD, 16'h0002, 1'b0, 0, 1'b1, prod);
        check("noise_unsigned", 64'(prod), 64'h0001_579A);

        // randomized mixed-mode run against the arithmetic model
        for (int n = 0; n < 1000; n++) begin
            rm = WIDTH'($urandom_range(0, 65535));
            rq = WIDTH'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            exp_q.push_back(model(rm, rq, rs));
            do_op(rm, rq, rs, $urandom_range(0, 2), 1'($urandom_range(0, 1)), prod);
            exp = exp_q.pop_front();
            check("random_prod", 64'(prod), 64'(exp));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
